// File: rtl/regfile_context_engine_pkg.sv
// Shared definitions for the register-file context save/restore sequencer.
// State encoding and register-file addressing constants.
package regfile_context_engine_pkg;

  localparam int RA_W = 5;
  localparam logic [RA_W-1:0] ZERO_REG = 5'd31;
  localparam int REG_BYTES_LOG2 = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE,
    ST_RD_REQ,
    ST_RD_WB,
    ST_DONE
  } state_t;

endpackage

// File: rtl/regfile_context_engine.sv
// Streams R0..LAST_REG between the register file and a memory-style bus.
// Save reads the register file into memory; restore reloads it from memory.
//
// state  | meaning
// IDLE   | waiting for start; samples mode and base_addr
// SAVE   | write R[idx] to base+8*idx, held until mem_ready
// RD_REQ | read base+8*idx, held until mem_ready; capture data into rf_d
// RD_WB  | one-cycle register-file write of rf_d into R[idx]
// DONE   | one-cycle completion pulse, still busy
module regfile_context_engine
  import regfile_context_engine_pkg::*;
#(
  parameter int N        = 64,
  parameter int AW       = 64,
  parameter int LAST_REG = 30
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            mode,
  input  logic [AW-1:0]   base_addr,
  output logic            busy,
  output logic            done,
  output logic [RA_W-1:0] rf_sa,
  input  logic [N-1:0]    rf_a,
  output logic [RA_W-1:0] rf_da,
  output logic [N-1:0]    rf_d,
  output logic            rf_write,
  output logic [AW-1:0]   mem_addr,
  output logic [N-1:0]    mem_wdata,
  output logic            mem_wr,
  output logic            mem_rd,
  input  logic [N-1:0]    mem_rdata,
  input  logic            mem_ready
);

  state_t          state_q, state_d;
  logic [RA_W-1:0] idx_q, idx_d;
  logic [AW-1:0]   base_q, base_d;
  logic [N-1:0]    rf_d_q, rf_d_d;
  logic            last_idx;
  logic [AW-1:0]   xfer_addr;

  assign last_idx  = (idx_q == RA_W'(LAST_REG));
  // Natural AW-bit addition gives the silent mod 2^AW wrap.
  assign xfer_addr = base_q + (AW'(idx_q) << REG_BYTES_LOG2);
  assign rf_d      = rf_d_q;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    rf_d_d    = rf_d_q;
    done      = 1'b0;
    rf_sa     = '0;
    rf_da     = ZERO_REG;
    rf_write  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          idx_d   = '0;
          state_d = mode ? ST_RD_REQ : ST_SAVE;
        end
      end
      ST_SAVE: begin
        rf_sa     = idx_q;
        mem_wr    = 1'b1;
        mem_wdata = rf_a;
        mem_addr  = xfer_addr;
        if (mem_ready) begin
          if (last_idx) state_d = ST_DONE;
          else          idx_d   = idx_q + 1'b1;
        end
      end
      ST_RD_REQ: begin
        mem_rd   = 1'b1;
        mem_addr = xfer_addr;
        if (mem_ready) begin
          rf_d_d  = mem_rdata;
          state_d = ST_RD_WB;
        end
      end
      ST_RD_WB: begin
        rf_write = 1'b1;
        rf_da    = idx_q;
        if (last_idx) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_RD_REQ;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      rf_d_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      rf_d_q  <= rf_d_d;
    end
  end

endmodule

// File: tb/tb_regfile_context_engine.sv
// Directed bench for regfile_context_engine with a register-file model,
// a memory responder and an in-order transfer scoreboard.
module tb_regfile_context_engine;

  localparam logic [63:0] PAT = 64'hA5A5_0000_0000_0000;
  localparam logic [63:0] INC = 64'h1111_1111;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [63:0] base_addr;
  logic        busy, done;
  logic [4:0]  rf_sa, rf_da;
  logic [63:0] rf_a, rf_d;
  logic        rf_write;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_wr, mem_rd;
  logic [63:0] mem_rdata;
  logic        mem_ready;

  regfile_context_engine dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
    .busy(busy), .done(done), .rf_sa(rf_sa), .rf_a(rf_a), .rf_da(rf_da), .rf_d(rf_d),
    .rf_write(rf_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  logic [63:0] regs [32];
  assign rf_a = regs[rf_sa];

  typedef struct {
    int          kind;   // 0 mem write, 1 mem read, 2 register-file write
    logic [63:0] addr;
    logic [63:0] data;
    int          idx;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  logic [63:0] tb_base;
  int          wr_cnt, rd_cnt, rfw_cnt, busy_cycles, done_cycle, n_done;
  bit          overlap_seen, zero_write_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input int kind, input logic [63:0] addr, input logic [63:0] data,
                          input int idx);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_unexpected kind observed=%0d expected=none", kind);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("sb_kind_%0d", e.idx), 64'(kind), 64'(e.kind));
      chk($sformatf("sb_addr_%0d", e.idx), addr, e.addr);
      chk($sformatf("sb_data_%0d", e.idx), data, e.data);
      chk($sformatf("sb_idx_%0d", e.idx), 64'(idx), 64'(e.idx));
    end
  endtask

  task automatic push_save(input logic [63:0] b);
    exp_t e;
    for (int k = 0; k <= 30; k++) begin
      e.kind = 0; e.addr = b + 64'(k) * 64'd8; e.data = regs[k]; e.idx = k;
      sbq.push_back(e);
    end
  endtask

  task automatic push_restore(input logic [63:0] b);
    exp_t e;
    for (int k = 0; k <= 30; k++) begin
      e.kind = 1; e.addr = b + 64'(k) * 64'd8; e.data = 64'd0; e.idx = 0;
      sbq.push_back(e);
      e.kind = 2; e.addr = 64'd0; e.data = PAT | 64'(k); e.idx = k;
      sbq.push_back(e);
    end
  endtask

  task automatic preload_ramp();
    for (int k = 0; k < 32; k++) regs[k] = (k == 31) ? 64'd0 : 64'(k) * INC;
  endtask

  task automatic check_idle(input string tag, input bit with_rf_d);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_rf_write"}, 64'(rf_write), 64'd0);
    chk({tag, "_mem_wr"}, 64'(mem_wr), 64'd0);
    chk({tag, "_mem_rd"}, 64'(mem_rd), 64'd0);
    chk({tag, "_rf_sa"}, 64'(rf_sa), 64'd0);
    chk({tag, "_rf_da"}, 64'(rf_da), 64'd31);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    if (with_rf_d) chk({tag, "_rf_d"}, rf_d, 64'd0);
  endtask

  // Cycle c is the clock period following the c-th edge after the start-sampling edge.
  task automatic run_op(input logic m, input logic [63:0] b, input bit every3, input int budget,
                        input bit noise, input bit use_abort, input logic [63:0] abort_addr,
                        output bit aborted);
    int rdy_cnt;
    aborted = 1'b0;
    rdy_cnt = 0;
    wr_cnt = 0; rd_cnt = 0; rfw_cnt = 0; busy_cycles = 0; done_cycle = -1; n_done = 0;
    overlap_seen = 1'b0; zero_write_seen = 1'b0;
    tb_base = b;
    @(negedge clock);
    start = 1'b1; mode = m; base_addr = b; mem_ready = 1'b0;
    @(posedge clock);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clock);
      if (use_abort && mem_rd && mem_addr == abort_addr) begin
        aborted = 1'b1;
        reset = 1'b0;
        break;
      end
      if (noise && n_done == 0) begin
        start = 1'b1; mode = 1'b1; base_addr = {$urandom(), $urandom()};
      end else begin
        start = 1'b0;
      end
      mem_ready = every3 ? (rdy_cnt % 3 == 2) : 1'b1;
      rdy_cnt++;
      mem_rdata = PAT | ((mem_addr - tb_base) >> 3);
      if (n_done > 0) begin
        chk("idle_after_done", 64'(busy), 64'd0);
        break;
      end
      if (busy) busy_cycles++;
      if (done) begin n_done++; done_cycle = c; end
      if (mem_wr && mem_rd) overlap_seen = 1'b1;
      if (rf_write && rf_da == 5'd31) zero_write_seen = 1'b1;
      if (mem_wr && mem_ready) begin wr_cnt++; sb_check(0, mem_addr, mem_wdata, int'(rf_sa)); end
      if (mem_rd && mem_ready) begin rd_cnt++; sb_check(1, mem_addr, 64'd0, 0); end
      if (rf_write) begin
        rfw_cnt++;
        sb_check(2, 64'd0, rf_d, int'(rf_da));
        regs[rf_da] = rf_d;
      end
    end
    start = 1'b0;
    if (!aborted) chk("op_completed", 64'(n_done), 64'd1);
  endtask

  bit ab;

  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b0; base_addr = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    preload_ramp();

    // 1: reset with random inputs, release, then asynchronous mid-cycle reset
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      start = 1'($urandom()); mode = 1'($urandom());
      base_addr = {$urandom(), $urandom()};
      mem_ready = 1'($urandom()); mem_rdata = {$urandom(), $urandom()};
    end
    #1 check_idle("in_reset", 1'b1);
    start = 1'b0; mem_ready = 1'b0;
    @(negedge clock) reset = 1'b1;
    @(negedge clock) check_idle("after_reset", 1'b1);
    start = 1'b1; mode = 1'b0; base_addr = 64'h1000; mem_ready = 1'b1;
    @(negedge clock) start = 1'b0;
    @(negedge clock) chk("pre_abort_mem_wr", 64'(mem_wr), 64'd1);
    @(posedge clock);
    #2 reset = 1'b0;
    #1 chk("async_mem_wr", 64'(mem_wr), 64'd0);
    chk("async_rf_write", 64'(rf_write), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    @(negedge clock) reset = 1'b1;

    // 2: save with mem_ready tied high
    push_save(64'h1000);
    run_op(1'b0, 64'h1000, 1'b0, 200, 1'b0, 1'b0, 64'd0, ab);
    chk("save_done_cycle", 64'(done_cycle), 64'd32);
    chk("save_busy_cycles", 64'(busy_cycles), 64'd32);
    chk("save_wr_cnt", 64'(wr_cnt), 64'd31);
    chk("save_rd_cnt", 64'(rd_cnt), 64'd0);
    chk("save_sb_empty", 64'(sbq.size()), 64'd0);

    // 3: restore with mem_ready every third cycle
    push_restore(64'h2000);
    run_op(1'b1, 64'h2000, 1'b1, 400, 1'b0, 1'b0, 64'd0, ab);
    chk("rest_rfw_cnt", 64'(rfw_cnt), 64'd31);
    chk("rest_rd_cnt", 64'(rd_cnt), 64'd31);
    chk("rest_wr_cnt", 64'(wr_cnt), 64'd0);
    chk("rest_zero_write", 64'(zero_write_seen), 64'd0);
    chk("rest_overlap", 64'(overlap_seen), 64'd0);
    chk("rest_sb_empty", 64'(sbq.size()), 64'd0);
    for (int k = 0; k <= 30; k++) chk($sformatf("rest_r%0d", k), regs[k], PAT | 64'(k));

    // 4: save with start/mode=1 hammered while busy and during DONE
    push_save(64'h4000);
    run_op(1'b0, 64'h4000, 1'b0, 200, 1'b1, 1'b0, 64'd0, ab);
    chk("noise_wr_cnt", 64'(wr_cnt), 64'd31);
    chk("noise_rd_cnt", 64'(rd_cnt), 64'd0);
    chk("noise_sb_empty", 64'(sbq.size()), 64'd0);

    // 5: reset during restore at idx 10, then a fresh save from idx 0
    preload_ramp();
    push_restore(64'h2000);
    run_op(1'b1, 64'h2000, 1'b0, 200, 1'b0, 1'b1, 64'h2000 + 64'd80, ab);
    chk("abort_hit", 64'(ab), 64'd1);
    #1 chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_rd", 64'(mem_rd), 64'd0);
    chk("abort_n_done", 64'(n_done), 64'd0);
    @(negedge clock) chk("abort_done_in_reset", 64'(done), 64'd0);
    reset = 1'b1;
    sbq.delete();
    for (int k = 0; k <= 30; k++)
      chk($sformatf("abort_r%0d", k), regs[k], (k < 10) ? (PAT | 64'(k)) : 64'(k) * INC);
    push_save(64'h3000);
    run_op(1'b0, 64'h3000, 1'b0, 200, 1'b0, 1'b0, 64'd0, ab);
    chk("resave_wr_cnt", 64'(wr_cnt), 64'd31);
    chk("resave_sb_empty", 64'(sbq.size()), 64'd0);

    // 6: address wrap past 2^64
    push_save(64'hFFFF_FFFF_FFFF_FFF0);
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 200, 1'b0, 1'b0, 64'd0, ab);
    chk("wrap_wr_cnt", 64'(wr_cnt), 64'd31);
    chk("wrap_sb_empty", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_context_engine.md
Name: regfile_context_engine

Overview:
- Multi-cycle sequencer that sits on the far side of the 32x64 register file ports.
- Save: drives the read-select port, streams R0..R30 out to a memory-style write bus.
- Restore: fetches 31 doublewords from memory and drives the destination-address/data/write port to reload R0..R30.
- Used for context switch and debug snapshot. R31 (hard zero) is never read or written.

Parameters:
N, 64, data width; matches register width.
AW, 64, memory byte-address width.
LAST_REG, 30, highest register index transferred.

Ports:
clock  in  1  posedge clock.
reset  in  1  asynchronous, active-low reset.
start  in  1  begin operation; sampled only in IDLE.
mode  in  1  0 = save (regfile->mem), 1 = restore (mem->regfile); sampled with start.
base_addr  in  AW  byte base address; sampled with start.
busy  out  1  high from the cycle after start is accepted through the DONE cycle.
done  out  1  one-cycle completion pulse.
rf_sa  out  5  register-file read select.
rf_a  in  N  register-file read data; combinational from rf_sa.
rf_da  out  5  register-file destination address.
rf_d  out  N  register-file write data.
rf_write  out  1  register-file write enable.
mem_addr  out  AW  byte address.
mem_wdata  out  N  write data.
mem_wr  out  1  write request.
mem_rd  out  1  read request.
mem_rdata  in  N  read data; valid when mem_ready=1.
mem_ready  in  1  transfer-complete strobe for the current request.

Behaviour:
- Reset (async, any state):
  - FSM returns to IDLE; idx=0.
  - busy=0, done=0, rf_write=0, mem_wr=0, mem_rd=0.
  - rf_sa=0, rf_da=31, rf_d=0, mem_addr=0.
- States: IDLE, SAVE, RD_REQ, RD_WB, DONE.
- IDLE:
  - start=1 latches mode and base_addr, clears idx, and moves to SAVE (mode=0) or RD_REQ (mode=1).
  - start=0: stay in IDLE.
- SAVE:
  - Drives rf_sa=idx, mem_wr=1, mem_wdata=rf_a (combinational pass-through), mem_addr=base+(idx<<3), computed mod 2^AW.
  - Outputs are held stable until mem_ready=1.
  - On mem_ready=1: if idx==LAST_REG go to DONE, else idx+1 and stay in SAVE.
- RD_REQ:
  - Drives mem_rd=1 and mem_addr=base+(idx<<3), held until mem_ready=1.
  - On mem_ready=1: register mem_rdata into rf_d, go to RD_WB.
- RD_WB: exactly one cycle with rf_write=1, rf_da=idx. Then go to DONE if idx==LAST_REG, else idx+1 and go to RD_REQ.
- DONE: done=1 for one cycle, busy=1; return to IDLE.
- Outside RD_WB: rf_write=0 and rf_da=31, so any stray write lands on the zero register.
- mem_wr and mem_rd are never high together. Neither is high outside SAVE / RD_REQ.
- Latency with mem_ready tied high:
  - Save: SAVE occupies 31 cycles; done is asserted 32 cycles after the start-sampling edge.
  - Restore: 62 transfer cycles; done is asserted 63 cycles after the start-sampling edge.
- Each wait cycle (mem_ready=0) adds exactly one cycle.
- start, mode and base_addr are ignored while busy. start in the DONE cycle is also ignored.
- Reset mid-operation: no partial completion and no done pulse. Registers already restored keep their new values. The next start restarts from idx 0.
- Address arithmetic wraps silently mod 2^AW. No error output.

Decomposition:
- Shared package (LegV8 common):
  - State encoding.
  - ZERO_REG=31.
  - REG_BYTES_LOG2=3.
  - Register-address width 5.
- Single module; no sub-module. The address adder and idx counter are inline.

Test Plan:
1. Reset: hold reset=0 with random inputs, release -> all outputs at reset values. Pulse reset=0 mid-cycle -> rf_write/mem_wr drop immediately.
2. Save, mem_ready=1, regfile preloaded Rk=k*64'h1111_1111, base=64'h1000:
   - 31 writes to 0x1000,0x1008,...,0x10F0 with matching data.
   - rf_sa sequence 0..30.
   - done at cycle 32; busy high cycles 1-32.
3. Restore, memory model returns 64'hA5A5_0000_0000_0000|k at base+8k, mem_ready high every 3rd cycle:
   - R0..R30 equal model values.
   - rf_da sequence 0..30; rf_write never with rf_da=31.
   - Exactly 31 rf_write pulses.
4. start=1 with mode=1 asserted repeatedly during a save -> ignored. Exactly 31 mem_wr transfers, no mem_rd, one done pulse.
5. Assert reset during restore at idx=10, release, start save:
   - R0..R9 restored, R10..R30 unchanged.
   - No done from aborted op; new save begins at idx 0.
6. base_addr=2^64-16, save -> addresses FFFF_FFFF_FFFF_FFF0, ..._FFF8, then 0x0, 0x8, ..., 0xE0.
